// File: rtl/pong_vga_renderer.sv
// pong_vga_renderer
//   Display stage of the pong core. Generates 640x480@60 VGA timing from
//   the pixel clock and draws ball, two paddles and the centre net on a
//   160x120 grid of 4x4 px cells. The four positions are copied into shadow
//   registers at the start of vblank. The shadow copy drives every pixel of
//   the next frame, so a frame never shows a half-updated position.
//
//   Ports
//     clk, rst_n       pixel clock, async active-low reset
//     ena              low freezes counters/shadows and idles all outputs
//     ball_x/ball_y    ball cell position
//     left_paddle_y    left paddle centre row (cells)
//     right_paddle_y   right paddle centre row (cells)
//     hsync/vsync      active-low syncs
//     display_on       visible area flag
//     red/green/blue   2-bit colour
//     frame_tick       one-cycle pulse at vblank start (advances game core)
//   All outputs are registered: one cycle after the counter state they show.

// Paddle vertical range test. The bounds are built in 9 bits so that the
// upper bound can pass 255. The lower bound clamps at 0 instead of wrapping.
module pong_paddle_hit #(
    parameter int CW     = 11,
    parameter int EXTENT = 6
) (
    input  logic [7:0]    paddle_y,
    input  logic [CW-1:0] cy,
    output logic          hit
);
    logic [8:0] lo;
    logic [8:0] hi;

    always_comb begin
        lo  = ({1'b0, paddle_y} < 9'(EXTENT)) ? 9'd0 : {1'b0, paddle_y} - 9'(EXTENT);
        hi  = {1'b0, paddle_y} + 9'(EXTENT);
        hit = (cy >= CW'(lo)) && (cy <= CW'(hi));
    end
endmodule

module pong_vga_renderer #(
    parameter int H_VISIBLE     = 640,
    parameter int H_FRONT       = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BACK        = 48,
    parameter int V_VISIBLE     = 480,
    parameter int V_FRONT       = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BACK        = 33,
    parameter int CELL_SHIFT    = 2,
    parameter int PADDLE_EXTENT = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ball_x,
    input  logic [7:0] ball_y,
    input  logic [7:0] left_paddle_y,
    input  logic [7:0] right_paddle_y,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [1:0] red,
    output logic [1:0] green,
    output logic [1:0] blue,
    output logic       frame_tick
);
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW        = $clog2(H_TOTAL);
    localparam int VW        = $clog2(V_TOTAL);
    localparam int CW        = ((HW > VW) ? HW : VW) + 1;
    localparam int GRID_W    = H_VISIBLE >> CELL_SHIFT;
    localparam int RIGHT_COL = GRID_W - 2;
    localparam int NET_COL   = GRID_W / 2;

    typedef struct packed {
        logic [7:0] bx;
        logic [7:0] by;
        logic [7:0] lp;
        logic [7:0] rp;
    } pos_t;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    pos_t          shadow;

    logic          h_last, v_last, latch;
    logic          vis, hs_nxt, vs_nxt;
    logic [CW-1:0] cx, cy;
    logic          ball_hit, net_hit, paddle_on;
    logic [5:0]    rgb_nxt;
    logic [1:0][7:0] pad_y;
    logic [1:0]      pad_hit;

    assign h_last = (h_cnt == HW'(H_TOTAL - 1));
    assign v_last = (v_cnt == VW'(V_TOTAL - 1));
    assign latch  = (h_cnt == '0) && (v_cnt == VW'(V_VISIBLE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (ena) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            shadow <= '0;
        else if (ena && latch)
            shadow <= '{bx: ball_x, by: ball_y, lp: left_paddle_y, rp: right_paddle_y};
    end

    // index 0 = left paddle, index 1 = right paddle
    assign pad_y = {shadow.rp, shadow.lp};

    for (genvar i = 0; i < 2; i++) begin : g_pad
        pong_paddle_hit #(.CW(CW), .EXTENT(PADDLE_EXTENT)) u_hit (
            .paddle_y (pad_y[i]),
            .cy       (cy),
            .hit      (pad_hit[i])
        );
    end

    always_comb begin
        vis    = (h_cnt < HW'(H_VISIBLE)) && (v_cnt < VW'(V_VISIBLE));
        hs_nxt = !((h_cnt >= HW'(H_VISIBLE + H_FRONT)) &&
                   (h_cnt <  HW'(H_VISIBLE + H_FRONT + H_SYNC)));
        vs_nxt = !((v_cnt >= VW'(V_VISIBLE + V_FRONT)) &&
                   (v_cnt <  VW'(V_VISIBLE + V_FRONT + V_SYNC)));
        cx     = CW'(h_cnt >> CELL_SHIFT);
        cy     = CW'(v_cnt >> CELL_SHIFT);

        ball_hit  = (cx == CW'(shadow.bx)) && (cy == CW'(shadow.by));
        paddle_on = ((cx == CW'(1))         && pad_hit[0]) ||
                    ((cx == CW'(RIGHT_COL)) && pad_hit[1]);
        // dashed net: lit on alternating groups of four cell rows
        net_hit   = (cx == CW'(NET_COL)) && !cy[2];

        rgb_nxt = 6'b00_00_00;
        if (vis) begin
            if (ball_hit)       rgb_nxt = 6'b11_11_00;
            else if (paddle_on) rgb_nxt = 6'b11_11_11;
            else if (net_hit)   rgb_nxt = 6'b01_01_01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            display_on <= 1'b0;
            red        <= '0;
            green      <= '0;
            blue       <= '0;
            frame_tick <= 1'b0;
        end else if (!ena) begin
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            display_on <= 1'b0;
            red        <= '0;
            green      <= '0;
            blue       <= '0;
            frame_tick <= 1'b0;
        end else begin
            hsync      <= hs_nxt;
            vsync      <= vs_nxt;
            display_on <= vis;
            {red, green, blue} <= rgb_nxt;
            frame_tick <= latch;
        end
    end
endmodule

// File: tb/tb_pong_vga_renderer.sv
// Bench for pong_vga_renderer. It uses a short frame (full 640 px width,
// 20 visible lines, tight porches) so several frames fit in a short run.
// The reference model derives the beam position from the number of
// enabled clocks since reset. It then applies the drawing rules with plain
// integer arithmetic.
module tb_pong_vga_renderer;
    localparam int HV = 640, HF = 8, HS = 16, HB = 8;
    localparam int VV = 20,  VF = 2, VS = 2,  VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int E  = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b1;
    logic [7:0] ball_x = '0, ball_y = '0, left_paddle_y = '0, right_paddle_y = '0;
    logic hsync, vsync, display_on, frame_tick;
    logic [1:0] red, green, blue;

    pong_vga_renderer #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .CELL_SHIFT(2), .PADDLE_EXTENT(E)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .ball_x(ball_x), .ball_y(ball_y),
        .left_paddle_y(left_paddle_y), .right_paddle_y(right_paddle_y),
        .hsync(hsync), .vsync(vsync), .display_on(display_on),
        .red(red), .green(green), .blue(blue), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int unsigned t = 0;
    int cyc = 0;
    int last_h, last_v;
    int sbx = 0, sby = 0, slp = 0, srp = 0;
    logic [9:0] exp_o, act_o;
    localparam logic [9:0] IDLE = 10'b11_0_000000_0;

    function automatic logic [5:0] ref_rgb(int h, int v);
        int cx, cy;
        bit lpad, rpad;
        if (h >= HV || v >= VV) return 6'b0;
        cx = h / 4;
        cy = v / 4;
        lpad = (cx == 1)   && (cy >= slp - E) && (cy <= slp + E);
        rpad = (cx == 158) && (cy >= srp - E) && (cy <= srp + E);
        if (cx == sbx && cy == sby) return 6'b111100;
        if (lpad || rpad)           return 6'b111111;
        if (cx == 80 && ((cy / 4) % 2) == 0) return 6'b010101;
        return 6'b0;
    endfunction

    // Advance model and DUT by one clock; leaves expected/actual in exp_o/act_o.
    task automatic step();
        int h, v;
        logic hs, vs, de, ft;
        logic [5:0] c;
        h = int'(t % HT);
        v = int'((t / HT) % VT);
        if (ena) begin
            hs = !(h >= HV + HF && h < HV + HF + HS);
            vs = !(v >= VV + VF && v < VV + VF + VS);
            de = (h < HV) && (v < VV);
            c  = ref_rgb(h, v);
            ft = (h == 0) && (v == VV);
        end else begin
            hs = 1; vs = 1; de = 0; c = 0; ft = 0;
        end
        exp_o  = {hs, vs, de, c, ft};
        last_h = h;
        last_v = v;
        if (ena && ft) begin
            sbx = ball_x; sby = ball_y; slp = left_paddle_y; srp = right_paddle_y;
        end
        if (ena) t++;
        @(posedge clk); #1;
        act_o = {hsync, vsync, display_on, red, green, blue, frame_tick};
        cyc++;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        act_o = {hsync, vsync, display_on, red, green, blue, frame_tick};
        checks++;
        if (act_o !== IDLE) begin
            errors++;
            $display("FAIL reset_state got=%b exp=%b", act_o, IDLE);
        end
        rst_n = 1'b1;
        t = 0; cyc = 0;
    endtask

    task automatic test_timing();
        int hf[$], hr[$], vf[$], vr[$], tk[$];
        logic phs = 1, pvs = 1;
        for (int i = 0; i < 33000; i++) begin
            if (i % 997 == 0) begin
                ball_x = 8'($urandom_range(0, 170));
                ball_y = 8'($urandom_range(0, 6));
                left_paddle_y  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(250, 255))
                                                             : 8'($urandom_range(0, 12));
                right_paddle_y = 8'($urandom_range(0, 12));
            end
            step();
            checks++;
            if (act_o !== exp_o) begin
                errors++;
                $display("FAIL timing_pixel cyc=%0d h=%0d v=%0d got=%b exp=%b",
                         cyc, last_h, last_v, act_o, exp_o);
            end
            if (phs && !act_o[9]) hf.push_back(cyc);
            if (!phs && act_o[9]) hr.push_back(cyc);
            if (pvs && !act_o[8]) vf.push_back(cyc);
            if (!pvs && act_o[8]) vr.push_back(cyc);
            if (act_o[0]) tk.push_back(cyc);
            phs = act_o[9];
            pvs = act_o[8];
        end
        checks++;
        if (hf.size() < 3 || hr.size() < 1 || hf[0] != HV + HF + 1 ||
            hf[1] - hf[0] != HT || hf[2] - hf[1] != HT || hr[0] - hf[0] != HS) begin
            errors++;
            $display("FAIL hsync_timing got first=%0d period=%0d width=%0d exp first=%0d period=%0d width=%0d",
                     (hf.size() > 0) ? hf[0] : -1, (hf.size() > 1) ? hf[1] - hf[0] : -1,
                     (hr.size() > 0 && hf.size() > 0) ? hr[0] - hf[0] : -1, HV + HF + 1, HT, HS);
        end
        checks++;
        if (vf.size() != 2 || vr.size() < 1 || vf[1] - vf[0] != HT * VT ||
            vr[0] - vf[0] != VS * HT || vf[0] != (VV + VF) * HT + 1) begin
            errors++;
            $display("FAIL vsync_timing got falls=%0d period=%0d width=%0d exp falls=2 period=%0d width=%0d",
                     vf.size(), (vf.size() > 1) ? vf[1] - vf[0] : -1,
                     (vr.size() > 0 && vf.size() > 0) ? vr[0] - vf[0] : -1, HT * VT, VS * HT);
        end
        checks++;
        if (tk.size() != 2 || tk[0] != VV * HT + 1 || tk[1] - tk[0] != HT * VT) begin
            errors++;
            $display("FAIL frame_tick got count=%0d first=%0d exp count=2 first=%0d period=%0d",
                     tk.size(), (tk.size() > 0) ? tk[0] : -1, VV * HT + 1, HT * VT);
        end
    endtask

    task automatic test_objects();
        int dh[10] = '{320, 320, 40, 4, 4,  632, 320, 320, 636, 8};
        int dv[10] = '{0,   3,   3,  0, 16, 12,  8,   16,  4,   0};
        logic [5:0] dx[10] = '{6'b111100, 6'b111100, 6'b000000, 6'b111111, 6'b111111,
                               6'b111111, 6'b010101, 6'b000000, 6'b000000, 6'b000000};
        int hits = 0;
        bit got = 0;
        ball_x = 80; ball_y = 0; left_paddle_y = 2; right_paddle_y = 3;
        for (int i = 0; i < 20000 && !got; i++) begin
            step();
            checks++;
            if (act_o !== exp_o) begin
                errors++;
                $display("FAIL obj_wait cyc=%0d got=%b exp=%b", cyc, act_o, exp_o);
            end
            got = exp_o[0];
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL obj_latch_timeout got=0 exp=1");
        end
        for (int i = 0; i < HT * VT - 1; i++) begin
            step();
            checks++;
            if (act_o !== exp_o) begin
                errors++;
                $display("FAIL obj_pixel h=%0d v=%0d got=%b exp=%b", last_h, last_v, act_o, exp_o);
            end
            for (int k = 0; k < 10; k++) begin
                if (last_h == dh[k] && last_v == dv[k]) begin
                    hits++;
                    checks++;
                    if (act_o[6:1] !== dx[k]) begin
                        errors++;
                        $display("FAIL obj_directed h=%0d v=%0d got=%b exp=%b",
                                 dh[k], dv[k], act_o[6:1], dx[k]);
                    end
                end
            end
            // move the ball mid-frame; it must not show until the next latch
            if (last_v == 2 && last_h == 660) ball_x = 10;
        end
        checks++;
        if (hits != 10) begin
            errors++;
            $display("FAIL obj_coverage got=%0d exp=10", hits);
        end
    endtask

    task automatic test_ena();
        bit seen = 0;
        bit fell = 0;
        int n = 0;
        int unsigned t_hold;
        for (int i = 0; i < 20000 && !(t % HT == 300 && (t / HT) % VT == 0); i++) begin
            step();
            checks++;
            if (act_o !== exp_o) begin
                errors++;
                $display("FAIL ena_pre h=%0d v=%0d got=%b exp=%b", last_h, last_v, act_o, exp_o);
            end
            if (last_h == 40 && last_v == 0) begin
                seen = 1;
                checks++;
                if (act_o[6:1] !== 6'b111100) begin
                    errors++;
                    $display("FAIL ball_moved got=%b exp=111100", act_o[6:1]);
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL ena_reach_timeout got=0 exp=1");
        end
        ena = 1'b0;
        t_hold = t;
        for (int i = 0; i < 1000; i++) begin
            step();
            checks++;
            if (act_o !== IDLE) begin
                errors++;
                $display("FAIL ena_idle cyc=%0d got=%b exp=%b", cyc, act_o, IDLE);
            end
        end
        ena = 1'b1;
        for (int i = 0; i < 2000 && !fell; i++) begin
            step();
            n++;
            checks++;
            if (act_o !== exp_o) begin
                errors++;
                $display("FAIL ena_resume h=%0d v=%0d got=%b exp=%b", last_h, last_v, act_o, exp_o);
            end
            fell = !act_o[9];
        end
        checks++;
        if (!fell || n != HV + HF - 300 + 1 || t_hold != t - n) begin
            errors++;
            $display("FAIL ena_hsync_delay got=%0d exp=%0d", fell ? n : -1, HV + HF - 300 + 1);
        end
    endtask

    task automatic test_reset_mid();
        bit got = 0;
        int n = 0;
        for (int i = 0; i < 500; i++) begin
            if (i == 100) ball_x = 20;
            step();
            checks++;
            if (act_o !== exp_o) begin
                errors++;
                $display("FAIL pre_reset h=%0d v=%0d got=%b exp=%b", last_h, last_v, act_o, exp_o);
            end
        end
        #1 rst_n = 1'b0;
        #1;
        act_o = {hsync, vsync, display_on, red, green, blue, frame_tick};
        checks++;
        if (act_o !== IDLE) begin
            errors++;
            $display("FAIL async_reset got=%b exp=%b", act_o, IDLE);
        end
        @(posedge clk); #1;
        act_o = {hsync, vsync, display_on, red, green, blue, frame_tick};
        checks++;
        if (act_o !== IDLE) begin
            errors++;
            $display("FAIL reset_hold got=%b exp=%b", act_o, IDLE);
        end
        rst_n = 1'b1;
        t = 0; sbx = 0; sby = 0; slp = 0; srp = 0;
        for (int i = 0; i < 20000 && !got; i++) begin
            step();
            n++;
            checks++;
            if (act_o !== exp_o) begin
                errors++;
                $display("FAIL post_reset h=%0d v=%0d got=%b exp=%b", last_h, last_v, act_o, exp_o);
            end
            got = act_o[0];
        end
        checks++;
        if (!got || n != VV * HT + 1) begin
            errors++;
            $display("FAIL reset_tick_delay got=%0d exp=%0d", got ? n : -1, VV * HT + 1);
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_objects();
        test_ena();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
